// File: rtl/exec_mem_unit.sv
// Single-cycle execute/memory stage: decode, ALU, compare, 3072-word DM, write-back.
// Define DM_TRACE_EN to print each committed data-memory write.
module exec_mem_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [15:0] imm16,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic [31:0] mem_rdata,
    output logic [31:0] wb_data,
    output logic [2:0]  compare,
    output logic        reg_write,
    output logic        mem_write,
    output logic [1:0]  dst_sel,
    output logic [2:0]  jump_signal
);

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI} alu_op_t;
    typedef enum logic [1:0] {B_RT, B_ZEXT, B_SEXT} b_sel_t;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

    localparam int unsigned DEPTH = 3072;

    logic [31:0] r_mem [DEPTH];

    logic        w_rtype, w_add, w_sub, w_jr;
    logic        w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    alu_op_t     w_alu_op;
    b_sel_t      w_b_sel;
    wb_sel_t     w_wb_sel;
    logic [31:0] w_zext, w_sext, w_b;
    logic        w_in_range;
    logic [11:0] w_idx;

    assign w_rtype = (op == 6'b000000);
    assign w_add   = w_rtype && (func[5:1] == 5'b10000);
    assign w_sub   = w_rtype && (func[5:1] == 5'b10001);
    assign w_jr    = w_rtype && (func == 6'b001000);
    assign w_ori   = (op == 6'b001101);
    assign w_lui   = (op == 6'b001111);
    assign w_lw    = (op == 6'b100011);
    assign w_sw    = (op == 6'b101011);
    assign w_beq   = (op == 6'b000100);
    assign w_j     = (op == 6'b000010);
    assign w_jal   = (op == 6'b000011);

    // Decoder flags are mutually exclusive; anything unmatched is a NOP.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        dst_sel     = 2'd0;
        jump_signal = 3'd0;
        w_alu_op    = ALU_ADD;
        w_b_sel     = B_RT;
        w_wb_sel    = WB_NONE;
        unique case (1'b1)
            w_add: begin
                reg_write = 1'b1;
                dst_sel   = 2'd1;
                w_wb_sel  = WB_ALU;
            end
            w_sub: begin
                reg_write = 1'b1;
                dst_sel   = 2'd1;
                w_alu_op  = ALU_SUB;
                w_wb_sel  = WB_ALU;
            end
            w_jr:  jump_signal = 3'd4;
            w_ori: begin
                reg_write = 1'b1;
                w_alu_op  = ALU_OR;
                w_b_sel   = B_ZEXT;
                w_wb_sel  = WB_ALU;
            end
            w_lui: begin
                reg_write = 1'b1;
                w_alu_op  = ALU_LUI;
                w_wb_sel  = WB_ALU;
            end
            w_lw: begin
                reg_write = 1'b1;
                w_b_sel   = B_SEXT;
                w_wb_sel  = WB_MEM;
            end
            w_sw: begin
                mem_write = 1'b1;
                w_b_sel   = B_SEXT;
            end
            w_beq: jump_signal = 3'd1;
            w_j:   jump_signal = 3'd2;
            w_jal: begin
                jump_signal = 3'd3;
                reg_write   = 1'b1;
                dst_sel     = 2'd2;
                w_wb_sel    = WB_LINK;
            end
            default: ;
        endcase
    end

    assign w_zext = {16'h0000, imm16};
    assign w_sext = {{16{imm16[15]}}, imm16};

    always_comb begin
        w_b = rt_data;
        case (w_b_sel)
            B_ZEXT:  w_b = w_zext;
            B_SEXT:  w_b = w_sext;
            default: w_b = rt_data;
        endcase
    end

    always_comb begin
        alu_out = rs_data + w_b;
        case (w_alu_op)
            ALU_SUB: alu_out = rs_data - w_b;
            ALU_OR:  alu_out = rs_data | w_b;
            ALU_LUI: alu_out = {imm16, 16'h0000};
            default: alu_out = rs_data + w_b;
        endcase
    end

    assign compare = {rs_data == w_b,
                      $signed(rs_data) < $signed(w_b),
                      $signed(rs_data) > $signed(w_b)};

    assign w_in_range = (alu_out < 32'h0000_3000);
    assign w_idx      = alu_out[13:2];
    assign mem_rdata  = w_in_range ? r_mem[w_idx] : 32'h0;

    always_comb begin
        wb_data = 32'h0;
        case (w_wb_sel)
            WB_ALU:  wb_data = alu_out;
            WB_MEM:  wb_data = mem_rdata;
            WB_LINK: wb_data = pc + 32'd4;
            default: wb_data = 32'h0;
        endcase
    end

    // Reset clears every word and wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
        end else if (mem_write && w_in_range) begin
            r_mem[w_idx] <= rt_data;
`ifdef DM_TRACE_EN
            $display("@%08h: *%08h <= %08h", pc, {alu_out[31:2], 2'b00}, rt_data);
`endif
        end
    end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Bench for exec_mem_unit: directed plan items plus randomized instructions
// checked against an instruction-level reference model.
module tb_exec_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, func;
    logic [15:0] imm16;
    logic [31:0] rs_data, rt_data, pc;
    logic [31:0] alu_out, mem_rdata, wb_data;
    logic [2:0]  compare;
    logic        reg_write, mem_write;
    logic [1:0]  dst_sel;
    logic [2:0]  jump_signal;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [3072];

    always #5 clk = ~clk;

    exec_mem_unit dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .imm16(imm16),
        .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
        .alu_out(alu_out), .mem_rdata(mem_rdata), .wb_data(wb_data),
        .compare(compare), .reg_write(reg_write), .mem_write(mem_write),
        .dst_sel(dst_sel), .jump_signal(jump_signal)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        return (a < 32'h3000) ? mdl[a[13:2]] : 32'h0;
    endfunction

    // One instruction for one cycle: check combinational outputs, then clock.
    task automatic run(input logic [5:0] o, input logic [5:0] f,
                       input logic [15:0] im, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] p,
                       input logic rst);
        logic [31:0] b, ea, ewb;
        logic        erw, emw, known;
        logic [1:0]  eds;
        logic [2:0]  ejs;
        reset = rst; op = o; func = f; imm16 = im;
        rs_data = rs; rt_data = rt; pc = p;
        b = rt; ea = rs + rt; ewb = 0;
        erw = 0; emw = 0; eds = 0; ejs = 0; known = 0;
        case (o)
            6'h00: case (f)
                6'h20, 6'h21: begin
                    ea = rs + rt; erw = 1; eds = 1; ewb = ea; known = 1;
                end
                6'h22, 6'h23: begin
                    ea = rs - rt; erw = 1; eds = 1; ewb = ea; known = 1;
                end
                6'h08: ejs = 4;
                default: ;
            endcase
            6'h0d: begin
                b = {16'h0, im}; ea = rs | b; erw = 1; ewb = ea; known = 1;
            end
            6'h0f: begin
                ea = {im, 16'h0}; erw = 1; ewb = ea; known = 1;
            end
            6'h23: begin
                b = 32'(signed'(im)); ea = rs + b; erw = 1;
                ewb = mread(ea); known = 1;
            end
            6'h2b: begin
                b = 32'(signed'(im)); ea = rs + b; emw = 1; known = 1;
            end
            6'h04: begin ejs = 1; known = 1; end
            6'h02: ejs = 2;
            6'h03: begin ejs = 3; erw = 1; eds = 2; ewb = p + 4; end
            default: ;
        endcase
        #1;
        if (known) begin
            chk("alu_out", alu_out, ea);
            chk("mem_rdata", mem_rdata, mread(ea));
        end
        chk("wb_data", wb_data, ewb);
        chk("compare", {29'h0, compare},
            {29'h0, rs == b, $signed(rs) < $signed(b), $signed(rs) > $signed(b)});
        chk("ctrl", {24'h0, reg_write, mem_write, dst_sel, 1'b0, jump_signal},
            {24'h0, erw, emw, eds, 1'b0, ejs});
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3072; i++) mdl[i] = 0;
        end else if (emw && ea < 32'h3000) begin
            mdl[ea[13:2]] = rt;
        end
        #1;
    endtask

    localparam logic [5:0] OPS [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
        6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f};
    localparam logic [5:0] FNS [5] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h08};

    initial begin
        for (int i = 0; i < 3072; i++) mdl[i] = 0;
        reset = 0; op = 0; func = 0; imm16 = 0;
        rs_data = 0; rt_data = 0; pc = 0;
        @(posedge clk); #1;
        run(6'h23, 0, 16'h0000, 0, 0, 0, 1'b1);
        run(6'h23, 0, 16'h2FF0, 0, 0, 0, 1'b1);
        chk("reset_rd", mem_rdata, 32'h0);
        run(6'h0d, 0, 16'h8001, 32'h1234, 0, 0, 1'b1);
        run(6'h0f, 0, 16'hABCD, 32'h5555, 32'h7777, 0, 1'b1);
        run(6'h2b, 0, 16'hFFFC, 32'h10, 32'hDEADBEEF, 0, 1'b1);
        run(6'h23, 0, 16'h0000, 32'h0C, 0, 0, 1'b1);
        chk("sw_lw_mem", mdl[3], 32'hDEADBEEF);
        run(6'h2b, 0, 16'h0000, 32'h3000, 32'h5, 0, 1'b1);
        run(6'h23, 0, 16'h0000, 32'h3000, 0, 0, 1'b1);
        run(6'h23, 0, 16'h0000, 32'h0, 0, 0, 1'b1);
        run(6'h04, 0, 16'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1);
        run(6'h04, 0, 16'h0, 32'hFFFFFFFE, 32'h1, 0, 1'b1);
        run(6'h00, 6'h22, 16'h0, 32'h80000000, 32'h1, 0, 1'b1);
        run(6'h03, 0, 16'h0, 0, 0, 32'h3000, 1'b1);
        run(6'h3f, 0, 16'h0, 32'h0C, 32'h1, 0, 1'b1);
        run(6'h23, 0, 16'h0000, 32'h0C, 0, 0, 1'b1);
        run(6'h2b, 0, 16'h0000, 32'h20, 32'h99, 0, 1'b0);
        run(6'h23, 0, 16'h0000, 32'h20, 0, 0, 1'b1);
        run(6'h23, 0, 16'h0000, 32'h0C, 0, 0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            int          k;
            logic [5:0]  o, f;
            logic [15:0] im;
            logic [31:0] rs, rt;
            k  = $urandom_range(0, 12);
            o  = (k == 12) ? 6'($urandom) : OPS[k];
            f  = (k < 5) ? FNS[k] : 6'($urandom);
            im = 16'($urandom);
            rs = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            if (o == 6'h23 || o == 6'h2b) begin
                rs = 32'($urandom_range(0, 63) * 4)
                   + (($urandom_range(0, 1) == 1) ? 32'h2F80 : 32'h0);
                im = 16'($signed(6'($urandom)));
            end
            run(o, f, im, rs, rt, $urandom, $urandom_range(0, 49) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
# exec_mem_unit

Single-cycle execute/memory stage of the MIPS-subset core. It decodes `op`/`func` into datapath control, selects ALU operands, and computes the ALU result and compare flags. It also holds the 3072-word data memory and forms the write-back value. Instruction fetch, register file and next-PC logic are outside this block.

## Interface
No parameters; memory depth fixed at 3072 words.
- `clk`  in  1  clock; memory writes on rising edge
- `reset`  in  1  reset, synchronous, active-low; clock clk
- `op`  in  6  instruction[31:26]
- `func`  in  6  instruction[5:0]
- `imm16`  in  16  instruction[15:0]
- `rs_data`  in  32  GRF read port 1 (rs)
- `rt_data`  in  32  GRF read port 2 (rt)
- `pc`  in  32  address of the current instruction
- `alu_out`  out  32  ALU result; also the memory byte address
- `mem_rdata`  out  32  data-memory read word
- `wb_data`  out  32  register write-back value
- `compare`  out  3  [2]=eq, [1]=signed lt, [0]=signed gt, comparing rs_data with ALU operand 2
- `reg_write`  out  1  GRF write enable
- `mem_write`  out  1  DM write strobe (decoded)
- `dst_sel`  out  2  destination register: 0=rt, 1=rd, 2=$31
- `jump_signal`  out  3  0=none, 1=beq, 2=j, 3=jal, 4=jr

## Operation
- Decode; all other opcode/func pairs decode as NOP: every control signal 0, no writes.
  - R-type (op=000000), by func:
    - add 100000 and addu 100001: rd=rs+rt
    - sub 100010 and subu 100011: rd=rs-rt
    - jr 001000: jump_signal=4, no reg_write
  - ori 001101: rt=rs|zext(imm)
  - lui 001111: rt={imm,16'h0}
  - lw 100011: rt=M[rs+sext(imm)]
  - sw 101011: M[rs+sext(imm)]=rt
  - beq 000100: jump_signal=1, ALU operand 2=rt
  - j 000010: jump_signal=2
  - jal 000011: jump_signal=3, reg_write=1, dst_sel=2, wb=pc+4
- ALU operations:
  - add/sub/addu/subu wrap modulo 2^32; no overflow trap or flag.
  - Operand 1 is always rs_data.
  - Operand 2 is rt_data (R-type, beq), zero-extended imm (ori), or sign-extended imm (lw/sw).
  - lui ignores both operands.
  - For j, jal, jr and NOP, alu_out is operand1+operand2, operand 2 is rt_data, and the result is don't-care.
- compare is always driven, regardless of instruction.
- wb_data:
  - alu_out for ALU instructions
  - mem_rdata for lw
  - pc+4 for jal
  - 0 otherwise
- Data memory:
  - 3072 x 32, word index alu_out[13:2], low two bits ignored.
  - Valid range is alu_out < 32'h0000_3000.
  - An out-of-range read returns 0; an out-of-range write is ignored.
  - Read is combinational.

## Timing
- Decode, ALU, compare, wb_data and mem_rdata are purely combinational, with zero-cycle latency.
- A DM write commits at the posedge of clk when mem_write=1, reset=1 and the address is in range. Data is rt_data.
- Read-during-write, same address, same cycle: mem_rdata shows the old word until after the edge. The new word is visible from the next cycle.
- A posedge with reset=0 clears all 3072 words to 0 and suppresses any write in that cycle. Reset deasserting mid-program resumes writes on the next edge.
- Control outputs have no reset value; they follow `op`/`func` at all times. The only state in the block is the memory.

## Configuration
- `DM_TRACE_EN` defined:
  - Each committed DM write prints `@<pc hex8>: *<addr hex8> <= <data hex8>`, where addr is alu_out with its low 2 bits cleared.
  - Ignored and reset-suppressed writes print nothing.
- Undefined: no display output. Functional behaviour is identical either way.

## Test plan
- Reset: hold reset=0 for 1 edge, then issue lw with rs_data=0 and imm at words 0 and 0xBFC -> mem_rdata=0.
- ori with rs=0x0000_1234, imm=0x8001 -> alu_out=0x0000_9235, reg_write=1, dst_sel=0. Then lui with imm=0xABCD -> alu_out=0xABCD_0000.
- sw with rs=0x10, imm=0xFFFC, rt=0xDEAD_BEEF -> write at 0x0C. Next cycle, lw at the same address -> mem_rdata=wb_data=0xDEAD_BEEF. During the write cycle, the same-address read shows the old value 0.
- sw to 0x3000 with rt=5 -> memory unchanged, no trace line; lw from 0x3000 -> mem_rdata=0.
- beq with rs=rt=-1 -> compare=3'b100, jump_signal=1. With rs=-2, rt=1 -> compare=3'b010. sub 0x8000_0000-1 -> 0x7FFF_FFFF, no trap.
- jal at pc=0x3000 -> wb_data=0x3004, dst_sel=2, reg_write=1. An undefined op 111111 -> all controls 0, no memory write.
